seg7_hexa5b_decoder: RTL and testbench
======================================

# seg7_hexa5b_decoder

- Sequential inverse of the team's 5-bit hexadecimal-to-7-segment mapping: watches a 7-segment pattern bus, waits until the pattern is stable for a configurable number of cycles, then decodes it back to its 5-bit code.
- Reports each decode with a one-cycle `valid` pulse, or an `error` pulse if the pattern is illegal.
- Used in PlaySeq as a self-check / loopback observer on the HEX display path (DE0-CV active-low segments), e.g. to confirm what the display logic is actually driving.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required before decode; legal range 2..255; counter width 8 bits.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; takes priority over every other input.
- `enable`  in  1  observer enable; low forces IDLE.
- `display`  in  7  segment pattern: bit 6 = segment g … bit 0 = segment a; active-low (0 = segment lit).
- `hexa`  out  5  last legally decoded code.
- `valid`  out  1  one-cycle pulse: `hexa` was just updated.
- `error`  out  1  one-cycle pulse: a stable pattern was not a legal code.

## Operation
Decode map (code:pattern, pattern written bit6..bit0):
- 00:1000000, 01:1111001, 02:0100100, 03:0110000, 04:0011001, 05:0010010, 06:0000010, 07:1111000
- 08:0000000, 09:0010000, 0A:0001000, 0B:0000011, 0C:1000110, 0D:0100001, 0E:0000110, 0F:0001110
- 10:1111110, 11:1111101, 12:1111011, 13:1110111, 14:1101111, 15:1011111, 16:0111111, 17:1111100
- 18:1110011, 19:1100111, 1A:1001111, 1B:0011111, 1C:1110001, 1D:1100011, 1E:1000111, 1F:0001111
- The 32 patterns are distinct. The other 96 patterns are illegal, including 1111111 (blank) unless the blank option is compiled in.

Internal registers: captured pattern `cap[6:0]`, stability counter `cnt[7:0]`, and state.

State machine:
- **IDLE**
  - `enable`=1: capture `display` into `cap`, set `cnt`=1, go to TRACK.
- **TRACK**
  - `enable`=0: go to IDLE. No pulse, even if this edge would have completed the count.
  - `display`≠`cap`: recapture `display`, set `cnt`=1, stay in TRACK.
  - `display`=`cap` and `cnt`+1 < `STABLE_CYCLES`: increment `cnt`.
  - `display`=`cap` and `cnt`+1 = `STABLE_CYCLES`: decode `cap`, go to HOLD.
    - Legal pattern: load `hexa`, pulse `valid`.
    - Illegal pattern: pulse `error`; `hexa` unchanged.
- **HOLD**
  - `enable`=0: go to IDLE.
  - `display`≠`cap`: recapture, set `cnt`=1, go to TRACK.
  - Otherwise stay in HOLD. A held pattern is reported exactly once.
- `valid` and `error` are never high in the same cycle. Each is high for exactly one cycle per decode.

## Timing
- Reset values: state IDLE, `hexa`=00000, `valid`=0, `error`=0, `cap`=0000000, `cnt`=0.
- All outputs are registered; nothing is combinational from input to output.
- Latency: pattern first sampled at edge k (capture) and held through edge k+N−1, with N=`STABLE_CYCLES`. `valid`/`error` is high during the cycle following edge k+N−1, and `hexa` changes at that same edge.
- A glitch of any length resets the count. The decode then occurs N edges after the last change.
- Reset asserted mid-TRACK or mid-pulse: every register returns to its reset value at that edge, and any pending pulse is lost.
- `enable` rising while `display` is already stable: the first decode occurs N edges later. There is no shortcut.

## Configuration
- `SEG7DEC_BLANK_EN`
  - Defined: a stable 1111111 is accepted silently. Go to HOLD with no `valid` or `error` pulse; `hexa` unchanged.
  - Undefined: 1111111 is treated as illegal and pulses `error`.

## Test plan
- Reset, then `enable`=1 with `display`=0110000 held (N=4): `valid` is high exactly one cycle, 4 edges after capture; `hexa`=00011; no further pulse while held.
- `display`=1111001 for 3 cycles, then 0100100 held: no pulse for 1111001; `valid` once with `hexa`=00010, 4 edges after the change.
- Stable 0101010 (illegal): `error` for one cycle; `hexa` keeps its prior value; `valid` stays 0.
- Stable 1111111: `error` pulse without `SEG7DEC_BLANK_EN`; no pulse and `hexa` unchanged with it.
- `reset` asserted on the edge where the count would complete (pattern 0001111): no `valid`; outputs are 0 next cycle. After release, a held 0001111 yields `hexa`=11111 after 4 edges.
- All 32 legal patterns applied sequentially, each held 5 cycles: 32 `valid` pulses, each with `hexa` equal to its code.

Source files
------------

// File: rtl/seg7_hexa5b_decoder.sv
// Loopback observer for an active-low 7-segment bus: waits for a pattern to be stable
// for STABLE_CYCLES samples, then decodes it to a 5-bit code. Optional macro: SEG7DEC_BLANK_EN.
module seg7_hexa5b_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] display,
  output logic [4:0] hexa,
  output logic       valid,
  output logic       error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // cnt counts samples already matched, so the decode edge is the one seeing cnt == N-1
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  localparam logic [6:0] SEG_LUT [32] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
    7'b1111110, 7'b1111101, 7'b1111011, 7'b1110111,
    7'b1101111, 7'b1011111, 7'b0111111, 7'b1111100,
    7'b1110011, 7'b1100111, 7'b1001111, 7'b0011111,
    7'b1110001, 7'b1100011, 7'b1000111, 7'b0001111
  };

  state_t     state_reg, state_next;
  logic [6:0] cap_reg, cap_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [4:0] hexa_reg, hexa_next;
  logic       valid_reg, valid_next;
  logic       error_reg, error_next;

  logic [31:0] match;
  logic [4:0]  code;
  logic        legal;
  logic        blank;
  logic        same;

  for (genvar gi = 0; gi < 32; gi++) begin : g_match
    assign match[gi] = (cap_reg == SEG_LUT[gi]);
  end

  // Patterns are distinct, so at most one match bit is ever set
  always_comb begin
    code  = 5'd0;
    legal = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (match[i]) begin
        code  = 5'(i);
        legal = 1'b1;
      end
    end
  end

`ifdef SEG7DEC_BLANK_EN
  assign blank = (cap_reg == 7'b1111111);
`else
  assign blank = 1'b0;
`endif

  assign same = (display == cap_reg);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cap_reg   <= 7'd0;
      cnt_reg   <= 8'd0;
      hexa_reg  <= 5'd0;
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cap_reg   <= cap_next;
      cnt_reg   <= cnt_next;
      hexa_reg  <= hexa_next;
      valid_reg <= valid_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = TRACK;
      end
      TRACK: begin
        if (!enable)                     state_next = IDLE;
        else if (!same)                  state_next = TRACK;
        else if (cnt_reg == STABLE_LAST) state_next = HOLD;
      end
      HOLD: begin
        if (!enable)    state_next = IDLE;
        else if (!same) state_next = TRACK;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cap_next   = cap_reg;
    cnt_next   = cnt_reg;
    hexa_next  = hexa_reg;
    valid_next = 1'b0;
    error_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          cap_next = display;
          cnt_next = 8'd1;
        end
      end
      TRACK: begin
        if (enable) begin
          if (!same) begin
            cap_next = display;
            cnt_next = 8'd1;
          end else if (cnt_reg == STABLE_LAST) begin
            if (legal) begin
              hexa_next  = code;
              valid_next = 1'b1;
            end else if (!blank) begin
              error_next = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      HOLD: begin
        if (enable && !same) begin
          cap_next = display;
          cnt_next = 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign hexa  = hexa_reg;
  assign valid = valid_reg;
  assign error = error_reg;

endmodule

// File: tb/tb_seg7_hexa5b_decoder.sv
// Self-checking bench for seg7_hexa5b_decoder: directed scenarios plus randomized segments,
// every cycle compared against a run-length reference model.
module tb_seg7_hexa5b_decoder;

  localparam int N = 4;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [6:0] display;
  logic [4:0] hexa;
  logic       valid;
  logic       error;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [6:0] lut [32];
  int         run;
  logic [6:0] m_prev;
  logic [4:0] m_hexa;
  logic       m_valid;
  logic       m_error;
  int         vcount;
  int         ecount;

  seg7_hexa5b_decoder #(.STABLE_CYCLES(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .display(display),
    .hexa   (hexa),
    .valid  (valid),
    .error  (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int lookup(input logic [6:0] p);
    int r;
    r = -1;
    for (int i = 0; i < 32; i++) if (lut[i] == p) r = i;
    return r;
  endfunction

  function automatic bit blank_ok(input logic [6:0] p);
`ifdef SEG7DEC_BLANK_EN
    return (p == 7'b1111111);
`else
    return (p == 7'b1111111) && 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, update the model at the edge, compare all outputs
  task automatic step(input logic en, input logic [6:0] disp, input logic rst);
    int idx;
    enable  = en;
    display = disp;
    reset   = rst;
    @(posedge clock);
    m_valid = 1'b0;
    m_error = 1'b0;
    if (rst) begin
      run    = 0;
      m_hexa = 5'd0;
    end else if (!en) begin
      run = 0;
    end else begin
      if (run > 0 && disp == m_prev) run++;
      else run = 1;
      m_prev = disp;
      if (run == N) begin
        idx = lookup(disp);
        if (idx >= 0) begin
          m_valid = 1'b1;
          m_hexa  = 5'(idx);
        end else if (!blank_ok(disp)) begin
          m_error = 1'b1;
        end
      end
    end
    #1;
    check("valid", 32'(valid), 32'(m_valid));
    check("error", 32'(error), 32'(m_error));
    check("hexa",  32'(hexa),  32'(m_hexa));
    if (valid === 1'b1) vcount++;
    if (error === 1'b1) ecount++;
  endtask

  task automatic hold(input logic en, input logic [6:0] disp, input int n);
    for (int i = 0; i < n; i++) step(en, disp, 1'b0);
    $display("seg en=%0b display=%b cycles=%0d -> hexa=%h valid_pulses=%0d error_pulses=%0d",
             en, disp, n, hexa, vcount, ecount);
  endtask

  initial begin
    lut = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
      7'b1111110, 7'b1111101, 7'b1111011, 7'b1110111,
      7'b1101111, 7'b1011111, 7'b0111111, 7'b1111100,
      7'b1110011, 7'b1100111, 7'b1001111, 7'b0011111,
      7'b1110001, 7'b1100011, 7'b1000111, 7'b0001111
    };
    run = 0; m_prev = '0; m_hexa = '0; m_valid = 0; m_error = 0;
    vcount = 0; ecount = 0;

    // reset state
    step(1'b0, 7'd0, 1'b1);
    step(1'b0, 7'd0, 1'b1);
    check("reset_hexa", 32'(hexa), 32'h0);

    // held 0110000 -> one valid pulse, hexa = 03
    vcount = 0;
    hold(1'b1, 7'b0110000, 8);
    check("t1_pulses", 32'(vcount), 32'd1);
    check("t1_hexa", 32'(hexa), 32'h03);

    // 1111001 for 3 cycles then 0100100 held
    vcount = 0;
    hold(1'b1, 7'b1111001, 3);
    check("t2_no_pulse", 32'(vcount), 32'd0);
    hold(1'b1, 7'b0100100, 6);
    check("t2_pulses", 32'(vcount), 32'd1);
    check("t2_hexa", 32'(hexa), 32'h02);

    // illegal pattern: error once, hexa kept
    vcount = 0; ecount = 0;
    hold(1'b1, 7'b0101010, 7);
    check("t3_errors", 32'(ecount), 32'd1);
    check("t3_valids", 32'(vcount), 32'd0);
    check("t3_hexa", 32'(hexa), 32'h02);

    // blank
    ecount = 0;
    hold(1'b1, 7'b1111111, 6);
`ifdef SEG7DEC_BLANK_EN
    check("t4_blank_errors", 32'(ecount), 32'd0);
`else
    check("t4_blank_errors", 32'(ecount), 32'd1);
`endif
    check("t4_hexa", 32'(hexa), 32'h02);

    // reset on the completing edge, then clean decode of 0001111
    vcount = 0;
    hold(1'b1, 7'b0001111, 3);
    step(1'b1, 7'b0001111, 1'b1);
    check("t5_rst_valid", 32'(valid), 32'd0);
    check("t5_rst_hexa", 32'(hexa), 32'h0);
    hold(1'b1, 7'b0001111, 5);
    check("t5_pulses", 32'(vcount), 32'd1);
    check("t5_hexa", 32'(hexa), 32'h1F);

    // enable low aborts a nearly complete count
    vcount = 0;
    hold(1'b1, 7'b0000110, 3);
    hold(1'b0, 7'b0000110, 2);
    hold(1'b1, 7'b0000110, 3);
    check("t6_no_pulse", 32'(vcount), 32'd0);
    hold(1'b1, 7'b0000110, 2);
    check("t6_pulses", 32'(vcount), 32'd1);

    // full sweep of legal codes
    step(1'b0, 7'd0, 1'b1);
    vcount = 0;
    for (int i = 0; i < 32; i++) begin
      hold(1'b1, lut[i], 5);
      check("sweep_hexa", 32'(hexa), 32'(i));
    end
    check("sweep_pulses", 32'(vcount), 32'd32);

    // randomized segments
    for (int s = 0; s < 120; s++) begin
      int sel;
      logic [6:0] p;
      logic en;
      sel = int'($urandom_range(0, 99));
      if (sel < 65)      p = lut[$urandom_range(0, 31)];
      else if (sel < 85) p = 7'($urandom);
      else               p = 7'b1111111;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) step(en, p, 1'b1);
      hold(en, p, int'($urandom_range(1, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
